// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encryption core: one round per clock, key schedule expanded on the fly.
// Byte i of every 128/256-bit bus is bits [8i+7:8i]; state bytes are column-major.
module aes256_encrypt_core (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic [127:0] data_in,
    input  logic [255:0] cipher_key,
    output logic [127:0] data_out,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column byte 0 (LSB) is row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] data_out_q, data_out_d;
    logic         done_q, done_d;

    logic [127:0] sb, sr, mc, rk, round_out;
    logic [255:0] key_next;
    logic [31:0]  sw_in, sw_out;
    logic [31:0]  n0, n1, n2, n3, n4, n5, n6, n7;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[8*i +: 8] = sbox(state_q[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
            end
            mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
        end
        rk        = round_q[0] ? key_q[255:128] : key_q[127:0];
        round_out = ((round_q == 4'd14) ? sr : mc) ^ rk;
    end

    // The window is refreshed in halves so one SubWord serves both updates:
    // odd rounds rebuild words 0..3 (RotWord+Rcon on old word 7), even rounds
    // rebuild words 4..7 from the freshly written word 3.
    always_comb begin
        sw_in    = round_q[0] ? {key_q[231:224], key_q[255:232]} : key_q[127:96];
        sw_out   = sub_word(sw_in);
        n0       = key_q[31:0]    ^ sw_out ^ {24'h0, rcon_q};
        n1       = key_q[63:32]   ^ n0;
        n2       = key_q[95:64]   ^ n1;
        n3       = key_q[127:96]  ^ n2;
        n4       = key_q[159:128] ^ sw_out;
        n5       = key_q[191:160] ^ n4;
        n6       = key_q[223:192] ^ n5;
        n7       = key_q[255:224] ^ n6;
        key_next = round_q[0] ? {key_q[255:128], n3, n2, n1, n0}
                              : {n7, n6, n5, n4, key_q[127:0]};
    end

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        key_d      = key_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        case (fsm_q)
            IDLE: begin
                done_d = 1'b0;
                if (En) begin
                    key_d   = cipher_key;
                    state_d = data_in ^ cipher_key[127:0];
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                key_d   = key_next;
                if (round_q[0]) begin
                    rcon_d = {rcon_q[6:0], 1'b0};
                end
                if (round_q == 4'd14) begin
                    data_out_d = round_out;
                    done_d     = 1'b1;
                    round_d    = 4'd0;
                    fsm_d      = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (!En) begin
                    done_d = 1'b0;
                    fsm_d  = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fsm_q      <= IDLE;
            state_q    <= '0;
            key_q      <= '0;
            round_q    <= '0;
            rcon_q     <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            key_q      <= key_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Directed and model-based checks for aes256_encrypt_core.
module tb_aes256_encrypt_core;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         En = 1'b0;
    logic [127:0] data_in = '0;
    logic [255:0] cipher_key = '0;
    logic [127:0] data_out;
    logic         done;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] sb_tbl [256];

    localparam logic [255:0] SP_KEY   = 256'hf4df1409a310982dd708613b072c351f81777d85f0ae732bbe71ca1510eb3d60;
    localparam logic [127:0] SP_PT    = 128'h2a179373117e3de9969f402ee2bec16b;
    localparam logic [127:0] SP_CT    = 128'hf881b13d7e5a4b063ca0d2b5bdd1eef3;
    localparam logic [255:0] FIPS_KEY = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FIPS_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] FIPS_CT  = 128'h8960494b9049fceabf456751cab7a28e;

    aes256_encrypt_core dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .En         (En),
        .data_in    (data_in),
        .cipher_key (cipher_key),
        .data_out   (data_out),
        .done       (done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box derived from the GF(2^8) inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb = x[7:0];
            for (int y = 1; y < 256; y++) begin
                yb = y[7:0];
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sb_tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [255:0] key, input logic [127:0] pt);
        logic [7:0] w [240];
        logic [7:0] st [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, b0;
        logic [127:0] res;
        for (int i = 0; i < 32; i++) w[i] = key[8*i +: 8];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            for (int k = 0; k < 4; k++) tmp[k] = w[4*(i-1)+k];
            if (i % 8 == 0) begin
                b0 = tmp[0];
                tmp[0] = sb_tbl[tmp[1]] ^ rc;
                tmp[1] = sb_tbl[tmp[2]];
                tmp[2] = sb_tbl[tmp[3]];
                tmp[3] = sb_tbl[b0];
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                for (int k = 0; k < 4; k++) tmp[k] = sb_tbl[tmp[k]];
            end
            for (int k = 0; k < 4; k++) w[4*i+k] = w[4*(i-8)+k] ^ tmp[k];
        end
        for (int i = 0; i < 16; i++) st[i] = pt[8*i +: 8] ^ w[i];
        for (int r = 1; r <= 14; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row+4*c] = sb_tbl[st[row + 4*((c+row)%4)]];
            for (int c = 0; c < 4; c++) begin
                if (r != 14) begin
                    st[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    st[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    st[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    st[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int row = 0; row < 4; row++) st[4*c+row] = t[4*c+row];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = st[i];
        return res;
    endfunction

    // Starts a block from IDLE and waits (bounded) for done; edges = 0 on timeout.
    task automatic launch(input logic [255:0] key, input logic [127:0] pt,
                          output int edges, output logic [127:0] ct, output bit early);
        logic [127:0] prev;
        prev = data_out;
        early = 1'b0;
        edges = 0;
        cipher_key = key;
        data_in = pt;
        En = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (done) begin
                edges = n;
                break;
            end
            if (data_out !== prev) early = 1'b1;
        end
        ct = data_out;
    endtask

    task automatic go_idle();
        En = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++;
        if (data_out !== 128'h0) $display("FAIL reset_data: got %h want 0", data_out); else pass_cnt++;
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL idle_done: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_sp800();
        int edges;
        logic [127:0] ct;
        bit early;
        launch(SP_KEY, SP_PT, edges, ct, early);
        total_cnt++;
        if (edges !== 15) $display("FAIL sp800_latency: got %0d edges want 15", edges); else pass_cnt++;
        total_cnt++;
        if (ct !== SP_CT) $display("FAIL sp800_data: got %h want %h", ct, SP_CT); else pass_cnt++;
        total_cnt++;
        if (early !== 1'b0) $display("FAIL sp800_intermediate: data_out moved before done"); else pass_cnt++;
        repeat (3) @(posedge Clk);
        #1;
        total_cnt++;
        if (done !== 1'b1 || data_out !== SP_CT)
            $display("FAIL sp800_hold: got done=%b data=%h want 1 %h", done, data_out, SP_CT);
        else pass_cnt++;
    endtask

    task automatic test_handshake();
        int edges;
        logic [127:0] ct, nk_pt;
        logic [255:0] nk;
        bit early;
        go_idle();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL handshake_drop: got done=%b want 0", done); else pass_cnt++;
        total_cnt++;
        if (data_out !== SP_CT) $display("FAIL handshake_keep: got %h want %h", data_out, SP_CT); else pass_cnt++;
        nk = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        nk_pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        launch(nk, nk_pt, edges, ct, early);
        total_cnt++;
        if (edges !== 15) $display("FAIL handshake_latency: got %0d edges want 15", edges); else pass_cnt++;
        total_cnt++;
        if (early !== 1'b0) $display("FAIL handshake_old_data: data_out changed before done"); else pass_cnt++;
        total_cnt++;
        if (ct !== ref_aes(nk, nk_pt)) $display("FAIL handshake_data: got %h want %h", ct, ref_aes(nk, nk_pt)); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_fips();
        int edges;
        logic [127:0] ct;
        bit early;
        launch(FIPS_KEY, FIPS_PT, edges, ct, early);
        total_cnt++;
        if (edges !== 15) $display("FAIL fips_latency: got %0d edges want 15", edges); else pass_cnt++;
        total_cnt++;
        if (ct !== FIPS_CT) $display("FAIL fips_data: got %h want %h", ct, FIPS_CT); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_reset_mid();
        int edges;
        logic [127:0] ct;
        bit early;
        cipher_key = SP_KEY;
        data_in = SP_PT;
        En = 1'b1;
        repeat (7) @(posedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        total_cnt++;
        if (done !== 1'b0 || data_out !== 128'h0)
            $display("FAIL midreset_clear: got done=%b data=%h want 0 0", done, data_out);
        else pass_cnt++;
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        launch(FIPS_KEY, FIPS_PT, edges, ct, early);
        total_cnt++;
        if (edges !== 15) $display("FAIL midreset_latency: got %0d edges want 15", edges); else pass_cnt++;
        total_cnt++;
        if (ct !== FIPS_CT) $display("FAIL midreset_data: got %h want %h", ct, FIPS_CT); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_input_stability();
        int edges;
        edges = 0;
        cipher_key = SP_KEY;
        data_in = SP_PT;
        En = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk); #1;
            if (n == 3) begin
                cipher_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
                data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            if (done) begin
                edges = n;
                break;
            end
        end
        total_cnt++;
        if (edges !== 15) $display("FAIL stability_latency: got %0d edges want 15", edges); else pass_cnt++;
        total_cnt++;
        if (data_out !== SP_CT) $display("FAIL stability_data: got %h want %h", data_out, SP_CT); else pass_cnt++;
        go_idle();
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [127:0] ct, pt, exp;
        logic [255:0] key;
        bit early;
        for (int k = 0; k < 100; k++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            exp = ref_aes(key, pt);
            launch(key, pt, edges, ct, early);
            total_cnt++;
            if (edges !== 15 || ct !== exp)
                $display("FAIL b2b_%0d: got %h after %0d edges want %h after 15", k, ct, edges, exp);
            else pass_cnt++;
            go_idle();
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_sp800();
        test_handshake();
        test_fips();
        test_reset_mid();
        test_input_stability();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
